// File: rtl/data_bus.sv
// data_bus: memory-side stage behind the core's load/store port.
// Decodes word addresses into a distributed-read RAM and an MMIO page (LED, SW, CNT, UART TX).
module data_bus #(
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned RAM_WORDS    = 192,
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] dout,
  output logic [DATA_W-1:0] din,
  input  logic [15:0]       sw,
  output logic [15:0]       led,
  output logic              uart_tx
);

  localparam int unsigned RAM_AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);

  localparam logic [ADDR_W-1:0] A_LED  = ADDR_W'(8'hF0);
  localparam logic [ADDR_W-1:0] A_SW   = ADDR_W'(8'hF1);
  localparam logic [ADDR_W-1:0] A_CNT  = ADDR_W'(8'hF2);
  localparam logic [ADDR_W-1:0] A_TX   = ADDR_W'(8'hF3);
  localparam logic [ADDR_W-1:0] A_STAT = ADDR_W'(8'hF4);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_t;

  logic [DATA_W-1:0] ram [RAM_WORDS];
  logic [RAM_AW-1:0] ram_idx;
  logic              is_ram;
  logic              wr_ram, wr_led, wr_cnt, wr_tx, wr_stat;

  logic [15:0]       led_q;
  logic [15:0]       sw_meta, sw_sync;
  logic [DATA_W-1:0] cnt_q;
  logic              overrun_q;
  logic              busy;

  tx_state_t         state_q, state_n;
  logic [BAUD_W-1:0] baud_q, baud_n;
  logic [2:0]        bit_q, bit_n;
  logic [7:0]        shift_q, shift_n;
  logic              tx_q, tx_n;

  assign is_ram  = 32'(address) < RAM_WORDS;
  assign ram_idx = RAM_AW'(address);

  assign wr_ram  = write && is_ram;
  assign wr_led  = write && (address == A_LED);
  assign wr_cnt  = write && (address == A_CNT);
  assign wr_tx   = write && (address == A_TX);
  assign wr_stat = write && (address == A_STAT);

  assign busy    = (state_q != S_IDLE);
  assign led     = led_q;
  assign uart_tx = tx_q;

  // Zero-latency read mux; the core samples din on the edge after it issues the load.
  always_comb begin
    din = '0;
    if (read) begin
      if (is_ram) begin
        din = ram[ram_idx];
      end else begin
        case (address)
          A_LED:   din = DATA_W'(led_q);
          A_SW:    din = DATA_W'(sw_sync);
          A_CNT:   din = cnt_q;
          A_STAT:  din = DATA_W'({overrun_q, busy});
          default: din = '0;
        endcase
      end
    end
  end

  // Data RAM: synchronous write, asynchronous read, contents not reset.
  always_ff @(posedge clk) begin
    if (wr_ram) ram[ram_idx] <= dout;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_q     <= '0;
      sw_meta   <= '0;
      sw_sync   <= '0;
      cnt_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      sw_meta <= sw;
      sw_sync <= sw_meta;
      if (wr_led) led_q <= dout[15:0];
      cnt_q <= wr_cnt ? dout : cnt_q + DATA_W'(1);
      // A TXDATA write that finds the transmitter busy (including its last STOP cycle) is dropped.
      if (wr_stat)            overrun_q <= 1'b0;
      else if (wr_tx && busy) overrun_q <= 1'b1;
    end
  end

  // UART transmitter state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_n;
      baud_q  <= baud_n;
      bit_q   <= bit_n;
      shift_q <= shift_n;
      tx_q    <= tx_n;
    end
  end

  // UART next state; the line level is registered from the next state so it tracks the frame exactly.
  always_comb begin
    state_n = state_q;
    baud_n  = baud_q;
    bit_n   = bit_q;
    shift_n = shift_q;
    tx_n    = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (wr_tx) begin
          state_n = S_START;
          baud_n  = '0;
          shift_n = dout[7:0];
        end
      end
      S_START: begin
        if (baud_q == BAUD_LAST) begin
          state_n = S_DATA;
          baud_n  = '0;
          bit_n   = '0;
        end else begin
          baud_n = baud_q + BAUD_W'(1);
        end
      end
      S_DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_n  = '0;
          shift_n = shift_q >> 1;
          if (bit_q == 3'd7) state_n = S_STOP;
          else               bit_n   = bit_q + 3'd1;
        end else begin
          baud_n = baud_q + BAUD_W'(1);
        end
      end
      S_STOP: begin
        if (baud_q == BAUD_LAST) begin
          state_n = S_IDLE;
          baud_n  = '0;
        end else begin
          baud_n = baud_q + BAUD_W'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase
    case (state_n)
      S_START: tx_n = 1'b0;
      S_DATA:  tx_n = shift_n[0];
      default: tx_n = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_data_bus.sv
// Self-checking bench for data_bus: randomized bus traffic checked against a behavioural model
// of the memory map, free-running counter and UART frame timeline.
module tb_data_bus;

  localparam int unsigned CPB   = 4;
  localparam int unsigned FRAME = 10 * CPB;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [7:0]  address = '0;
  logic [31:0] dout = '0;
  logic [31:0] din;
  logic [15:0] sw = '0;
  logic [15:0] led;
  logic        uart_tx;

  data_bus #(.ADDR_W(8), .DATA_W(32), .RAM_WORDS(192), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .read(read), .write(write), .address(address),
    .dout(dout), .din(din), .sw(sw), .led(led), .uart_tx(uart_tx)
  );

  always #5 clk = ~clk;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;
  int unsigned cyc = 0;

  // Reference model state
  logic [31:0] ram_m [256];
  logic [7:0]  wq [$];
  logic [15:0] led_m = '0;
  logic [31:0] cnt_val = '0;
  int unsigned cnt_cyc = 0;
  bit          tx_on = 1'b0;
  int unsigned tx_cyc = 0;
  logic [7:0]  tx_byte = '0;
  bit          ovr_m = 1'b0;

  logic [31:0] obs_din, exp_din;
  logic        obs_tx, exp_tx;

  function automatic bit m_busy();
    return tx_on && ((cyc - tx_cyc) < FRAME);
  endfunction

  // Line level from the frame timeline: start bit, 8 data bits LSB first, stop bit.
  function automatic logic m_tx();
    int o;
    if (!m_busy()) return 1'b1;
    o = int'((cyc - tx_cyc) / CPB);
    if (o == 0) return 1'b0;
    if (o == 9) return 1'b1;
    return tx_byte[o-1];
  endfunction

  function automatic logic [31:0] m_read(input logic [7:0] a);
    if (a < 8'd192) return ram_m[a];
    case (a)
      8'hF0:   return {16'h0, led_m};
      8'hF1:   return {16'h0, sw};
      8'hF2:   return cnt_val + (cyc - cnt_cyc);
      8'hF4:   return {30'h0, ovr_m, m_busy()};
      default: return 32'h0;
    endcase
  endfunction

  function automatic void m_write(input logic [7:0] a, input logic [31:0] d);
    if (a < 8'd192) begin
      ram_m[a] = d;
      wq.push_back(a);
    end else begin
      case (a)
        8'hF0: led_m = d[15:0];
        8'hF2: begin cnt_val = d; cnt_cyc = cyc + 1; end
        8'hF3: begin
          if (m_busy()) ovr_m = 1'b1;
          else begin tx_on = 1'b1; tx_cyc = cyc + 1; tx_byte = d[7:0]; end
        end
        8'hF4: ovr_m = 1'b0;
        default: ;
      endcase
    end
  endfunction

  function automatic void m_reset();
    led_m = '0; cnt_val = '0; cnt_cyc = cyc; tx_on = 1'b0; ovr_m = 1'b0;
  endfunction

  // One bus cycle: starts just after a falling edge, samples before the rising edge.
  task automatic bus(input logic rd, input logic wr, input logic [7:0] a, input logic [31:0] d);
    read = rd; write = wr; address = a; dout = d;
    #1;
    obs_din = din;
    obs_tx  = uart_tx;
    exp_din = rd ? m_read(a) : 32'h0;
    exp_tx  = m_tx();
    if (wr) m_write(a, d);
    @(posedge clk);
    cyc++;
    @(negedge clk);
    read = 1'b0; write = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    read = 1'b1; address = 8'hF2;
    #1;
    total_cnt++;
    if (led !== 16'h0 || uart_tx !== 1'b1 || din !== 32'h0)
      $display("FAIL reset_outputs: led=%h tx=%b cnt=%h, want 0000/1/00000000", led, uart_tx, din);
    else pass_cnt++;
    read = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    foreach (address_list[i]) begin
      bus(1'b1, 1'b0, address_list[i], 32'h0);
      total_cnt++;
      if (obs_din !== exp_din) $display("FAIL post_reset_rd %h: got %h want %h", address_list[i], obs_din, exp_din);
      else pass_cnt++;
    end
  endtask

  logic [7:0] address_list [4] = '{8'hF2, 8'hF2, 8'hF4, 8'hF0};

  task automatic test_ram();
    logic [7:0] a;
    bus(1'b0, 1'b1, 8'h05, 32'hDEADBEEF);
    bus(1'b0, 1'b1, 8'h06, 32'h0);
    bus(1'b1, 1'b0, 8'h05, 32'h0);
    total_cnt++;
    if (obs_din !== 32'hDEADBEEF) $display("FAIL ram_05: got %h want deadbeef", obs_din); else pass_cnt++;
    bus(1'b1, 1'b0, 8'h06, 32'h0);
    total_cnt++;
    if (obs_din !== 32'h0) $display("FAIL ram_06: got %h want 00000000", obs_din); else pass_cnt++;
    for (int i = 0; i < 16; i++) bus(1'b0, 1'b1, 8'(i), $urandom);
    for (int i = 0; i < 20; i++) bus(1'b0, 1'b1, 8'($urandom_range(191)), $urandom);
    bus(1'b0, 1'b1, 8'd191, $urandom);
    for (int i = 0; i < 30; i++) begin
      a = (i == 0) ? 8'd191 : wq[$urandom_range(wq.size() - 1)];
      bus(1'b1, 1'b0, a, 32'h0);
      total_cnt++;
      if (obs_din !== exp_din) $display("FAIL ram_rand %h: got %h want %h", a, obs_din, exp_din);
      else pass_cnt++;
    end
  endtask

  task automatic test_unmapped();
    logic [7:0] a;
    bus(1'b0, 1'b1, 8'hC8, 32'h1234);
    bus(1'b1, 1'b0, 8'hC8, 32'h0);
    total_cnt++;
    if (obs_din !== 32'h0) $display("FAIL unmapped_c8: got %h want 00000000", obs_din); else pass_cnt++;
    for (int i = 0; i < 12; i++) begin
      a = (i % 3 == 0) ? 8'hF3 : ((i % 3 == 1) ? 8'($urandom_range(239, 192)) : 8'($urandom_range(255, 245)));
      bus(1'b1, 1'b0, a, 32'h0);
      total_cnt++;
      if (obs_din !== exp_din) $display("FAIL unmapped_rd %h: got %h want %h", a, obs_din, exp_din);
      else pass_cnt++;
      a = 8'($urandom);
      bus(1'b0, 1'b0, a, 32'h0);
      total_cnt++;
      if (obs_din !== 32'h0) $display("FAIL idle_rd %h: got %h want 00000000", a, obs_din);
      else pass_cnt++;
    end
  endtask

  task automatic test_led_sw();
    logic [31:0] d;
    for (int i = 0; i < 4; i++) begin
      sw = (i == 0) ? 16'hA5A5 : 16'($urandom);
      bus(1'b0, 1'b0, 8'h0, 32'h0);
      bus(1'b0, 1'b0, 8'h0, 32'h0);
      bus(1'b1, 1'b0, 8'hF1, 32'h0);
      total_cnt++;
      if (obs_din !== exp_din) $display("FAIL sw_sync: got %h want %h", obs_din, exp_din); else pass_cnt++;
      d = (i == 0) ? 32'h0001FFFF : $urandom;
      bus(1'b0, 1'b1, 8'hF0, d);
      total_cnt++;
      if (led !== led_m) $display("FAIL led_out: got %h want %h", led, led_m); else pass_cnt++;
      bus(1'b1, 1'b0, 8'hF0, 32'h0);
      total_cnt++;
      if (obs_din !== exp_din) $display("FAIL led_rd: got %h want %h", obs_din, exp_din); else pass_cnt++;
    end
  endtask

  task automatic test_counter();
    int unsigned gap;
    bus(1'b0, 1'b1, 8'hF2, 32'hFFFFFFFE);
    bus(1'b0, 1'b0, 8'h0, 32'h0);
    bus(1'b1, 1'b0, 8'hF2, 32'h0);
    total_cnt++;
    if (obs_din !== 32'hFFFFFFFF) $display("FAIL cnt_ffff: got %h want ffffffff", obs_din); else pass_cnt++;
    bus(1'b1, 1'b0, 8'hF2, 32'h0);
    total_cnt++;
    if (obs_din !== 32'h0) $display("FAIL cnt_wrap: got %h want 00000000", obs_din); else pass_cnt++;
    for (int i = 0; i < 6; i++) begin
      bus(1'b0, 1'b1, 8'hF2, $urandom);
      gap = $urandom_range(5);
      for (int k = 0; k < int'(gap); k++) bus(1'b0, 1'b0, 8'h0, 32'h0);
      bus(1'b1, 1'b0, 8'hF2, 32'h0);
      total_cnt++;
      if (obs_din !== exp_din) $display("FAIL cnt_rand: got %h want %h", obs_din, exp_din); else pass_cnt++;
    end
  endtask

  task automatic test_uart_frame();
    logic [7:0] b;
    for (int f = 0; f < 2; f++) begin
      b = (f == 0) ? 8'h55 : 8'($urandom);
      bus(1'b0, 1'b1, 8'hF3, {24'($urandom), b});
      for (int k = 0; k <= int'(FRAME); k++) begin
        bus(1'b1, 1'b0, 8'hF4, 32'h0);
        total_cnt++;
        if (obs_tx !== exp_tx || obs_din !== exp_din)
          $display("FAIL uart_frame k=%0d: tx=%b st=%h want tx=%b st=%h", k, obs_tx, obs_din, exp_tx, exp_din);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_overrun();
    bus(1'b0, 1'b1, 8'hF3, 32'h41);
    for (int k = 0; k < int'(FRAME) + 2; k++) begin
      if (k == 10) bus(1'b0, 1'b1, 8'hF3, 32'h42);
      else         bus(1'b1, 1'b0, 8'hF4, 32'h0);
      total_cnt++;
      if (obs_tx !== exp_tx || obs_din !== exp_din)
        $display("FAIL overrun_frame k=%0d: tx=%b st=%h want tx=%b st=%h", k, obs_tx, obs_din, exp_tx, exp_din);
      else pass_cnt++;
    end
    bus(1'b0, 1'b1, 8'hF4, $urandom);
    bus(1'b1, 1'b0, 8'hF4, 32'h0);
    total_cnt++;
    if (obs_din !== exp_din) $display("FAIL overrun_clear: got %h want %h", obs_din, exp_din); else pass_cnt++;
    // A write landing on the last STOP cycle is treated as busy.
    bus(1'b0, 1'b1, 8'hF3, 32'($urandom));
    for (int k = 0; k < int'(FRAME) + 3; k++) begin
      if (k == int'(FRAME) - 1) bus(1'b0, 1'b1, 8'hF3, 32'h3C);
      else                      bus(1'b1, 1'b0, 8'hF4, 32'h0);
      total_cnt++;
      if (obs_tx !== exp_tx || obs_din !== exp_din)
        $display("FAIL stop_edge k=%0d: tx=%b st=%h want tx=%b st=%h", k, obs_tx, obs_din, exp_tx, exp_din);
      else pass_cnt++;
    end
    bus(1'b0, 1'b1, 8'hF4, 32'h0);
  endtask

  task automatic test_back_to_back();
    logic [7:0]  a;
    logic        r, w;
    logic [31:0] d;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(3))
        0: a = 8'hF0;
        1: a = 8'hF2;
        default: a = 8'($urandom_range(15));
      endcase
      r = 1'($urandom); w = 1'($urandom); d = $urandom;
      if (i < 4) begin r = 1'b1; w = 1'b1; end
      bus(r, w, a, d);
      total_cnt++;
      if (obs_din !== exp_din) $display("FAIL b2b %h r%b w%b: got %h want %h", a, r, w, obs_din, exp_din);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    bus(1'b0, 1'b1, 8'hF0, 32'h0000BEEF);
    bus(1'b0, 1'b1, 8'hF3, 32'h00);
    bus(1'b1, 1'b0, 8'hF4, 32'h0);
    total_cnt++;
    if (obs_tx !== 1'b0) $display("FAIL mid_start: tx=%b want 0", obs_tx); else pass_cnt++;
    rst = 1'b1;
    #1;
    total_cnt++;
    if (uart_tx !== 1'b1 || led !== 16'h0)
      $display("FAIL mid_reset: tx=%b led=%h want 1/0000", uart_tx, led);
    else pass_cnt++;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    for (int k = 0; k < 6; k++) begin
      bus(1'b1, 1'b0, 8'hF4, 32'h0);
      total_cnt++;
      if (obs_din !== 32'h0 || obs_tx !== 1'b1)
        $display("FAIL after_reset k=%0d: st=%h tx=%b want 00000000/1", k, obs_din, obs_tx);
      else pass_cnt++;
    end
    bus(1'b1, 1'b0, 8'hF2, 32'h0);
    total_cnt++;
    if (obs_din !== exp_din) $display("FAIL cnt_after_reset: got %h want %h", obs_din, exp_din); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_ram();
    test_unmapped();
    test_led_sw();
    test_counter();
    test_uart_frame();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
